// File: rtl/fpu_inq_sched_if.sv
// Handshake bundle between the PCX request decode, the inq SRAM and the
// pipe-load logic of the FPU input-queue issue scheduler.
interface fpu_inq_sched_if #(
    parameter int AW = 4
);
    logic          wr_vld;
    logic [1:0]    wr_pipe;
    logic          a1stg_step;
    logic          m1stg_step;
    logic          d1stg_step;
    logic          inq_we;
    logic [AW-1:0] inq_wraddr;
    logic          inq_read_en;
    logic [AW-1:0] inq_rdaddr;
    logic          inq_add;
    logic          inq_mul;
    logic          inq_div;
    logic [AW:0]   inq_cnt;
    logic          inq_full;
    logic          inq_ovfl;

    modport master (
        output wr_vld, wr_pipe, a1stg_step, m1stg_step, d1stg_step,
        input  inq_we, inq_wraddr, inq_read_en, inq_rdaddr,
        input  inq_add, inq_mul, inq_div, inq_cnt, inq_full, inq_ovfl
    );

    modport slave (
        input  wr_vld, wr_pipe, a1stg_step, m1stg_step, d1stg_step,
        output inq_we, inq_wraddr, inq_read_en, inq_rdaddr,
        output inq_add, inq_mul, inq_div, inq_cnt, inq_full, inq_ovfl
    );
endinterface

// File: rtl/fpu_inq_sched.sv
// FPU input-queue issue scheduler: allocates SRAM slots to decoded requests,
// keeps one ordered slot list per pipe (add/mul/div) and round-robin
// arbitrates the single SRAM read port among the pipes, so a stalled pipe
// never blocks the others.
module fpu_inq_sched #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic           rclk,
    input  logic           grst,
    fpu_inq_sched_if.slave bus
);
    localparam int NP = 3;

    typedef enum logic [1:0] {
        RR_ADD = 2'd0,
        RR_MUL = 2'd1,
        RR_DIV = 2'd2
    } rr_e;

    // Registered state
    logic [DEPTH-1:0] free_q, free_d;
    logic [AW-1:0]    fifo_q [NP][DEPTH];
    logic [AW-1:0]    fifo_d [NP][DEPTH];
    logic [AW-1:0]    wptr_q [NP];
    logic [AW-1:0]    wptr_d [NP];
    logic [AW-1:0]    rptr_q [NP];
    logic [AW-1:0]    rptr_d [NP];
    logic [AW:0]      fcnt_q [NP];
    logic [AW:0]      fcnt_d [NP];
    logic [AW:0]      cnt_q, cnt_d;
    rr_e              rr_q, rr_d;
    logic             ovfl_q, ovfl_d;

    // Combinational helpers
    logic             full_s;
    logic             wr_req_s;
    logic             wr_acc_s;
    logic [1:0]       wr_idx_s;
    logic             free_any_s;
    logic [AW-1:0]    free_slot_s;
    logic [NP-1:0]    elig_s;
    logic             gnt_s;
    logic [1:0]       gnt_idx_s;
    logic [AW-1:0]    head_s;

    // Write qualification; reset suppresses both allocation and overflow.
    always_comb begin
        full_s   = (cnt_q == (AW+1)'(DEPTH));
        wr_req_s = bus.wr_vld && (bus.wr_pipe != 2'b00) && !grst;
        wr_idx_s = bus.wr_pipe - 2'd1;
        wr_acc_s = wr_req_s && !full_s && free_any_s;
    end

    // Lowest-index free slot, scanning upward and keeping the first hit.
    always_comb begin
        free_any_s  = 1'b0;
        free_slot_s = {AW{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            free_slot_s = (free_q[i] && !free_any_s) ? AW'(i) : free_slot_s;
            free_any_s  = free_any_s | free_q[i];
        end
    end

    // Eligibility from registered FIFO counts: a write is visible only next cycle.
    always_comb begin
        elig_s[0] = (fcnt_q[0] != {(AW+1){1'b0}}) && bus.a1stg_step && !grst;
        elig_s[1] = (fcnt_q[1] != {(AW+1){1'b0}}) && bus.m1stg_step && !grst;
        elig_s[2] = (fcnt_q[2] != {(AW+1){1'b0}}) && bus.d1stg_step && !grst;
    end

    // Round-robin search starting at rr, first eligible pipe wins.
    always_comb begin
        logic [2:0] sum;
        logic [2:0] cand;
        logic       take;
        gnt_s     = 1'b0;
        gnt_idx_s = 2'd0;
        sum       = 3'd0;
        cand      = 3'd0;
        take      = 1'b0;
        for (int k = 0; k < NP; k++) begin
            sum       = 3'(rr_q) + 3'(k);
            cand      = (sum >= 3'd3) ? (sum - 3'd3) : sum;
            take      = !gnt_s && elig_s[cand[1:0]];
            gnt_idx_s = take ? cand[1:0] : gnt_idx_s;
            gnt_s     = gnt_s | take;
        end
        head_s = fifo_q[gnt_idx_s][rptr_q[gnt_idx_s]];
    end

    // Next-state: allocate/push on write, pop/free on issue, advance rr.
    always_comb begin
        free_d = free_q;
        fifo_d = fifo_q;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        fcnt_d = fcnt_q;
        rr_d   = rr_q;
        ovfl_d = ovfl_q;
        if (wr_acc_s) begin
            free_d[free_slot_s]                = 1'b0;
            fifo_d[wr_idx_s][wptr_q[wr_idx_s]] = free_slot_s;
            wptr_d[wr_idx_s]                   = wptr_q[wr_idx_s] + {{(AW-1){1'b0}}, 1'b1};
            fcnt_d[wr_idx_s]                   = fcnt_q[wr_idx_s] + {{AW{1'b0}}, 1'b1};
        end else begin
            // A valid write that finds the queue full latches overflow, even
            // if an issue frees a slot in the same cycle.
            ovfl_d = ovfl_q | (wr_req_s && full_s);
        end
        if (gnt_s) begin
            free_d[head_s]    = 1'b1;
            rptr_d[gnt_idx_s] = rptr_q[gnt_idx_s] + {{(AW-1){1'b0}}, 1'b1};
            fcnt_d[gnt_idx_s] = fcnt_d[gnt_idx_s] - {{AW{1'b0}}, 1'b1};
            case (gnt_idx_s)
                2'd0:    rr_d = RR_MUL;
                2'd1:    rr_d = RR_DIV;
                default: rr_d = RR_ADD;
            endcase
        end else begin
            rr_d = rr_q;
        end
        cnt_d = cnt_q + {{AW{1'b0}}, wr_acc_s} - {{AW{1'b0}}, gnt_s};
    end

    // State register with synchronous reset that discards all queued entries.
    always_ff @(posedge rclk) begin
        if (grst) begin
            free_q <= {DEPTH{1'b1}};
            for (int p = 0; p < NP; p++) begin
                wptr_q[p] <= {AW{1'b0}};
                rptr_q[p] <= {AW{1'b0}};
                fcnt_q[p] <= {(AW+1){1'b0}};
                for (int i = 0; i < DEPTH; i++) begin
                    fifo_q[p][i] <= {AW{1'b0}};
                end
            end
            cnt_q  <= {(AW+1){1'b0}};
            rr_q   <= RR_ADD;
            ovfl_q <= 1'b0;
        end else begin
            free_q <= free_d;
            fifo_q <= fifo_d;
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            fcnt_q <= fcnt_d;
            cnt_q  <= cnt_d;
            rr_q   <= rr_d;
            ovfl_q <= ovfl_d;
        end
    end

    // Write and issue strobes are same-cycle; occupancy comes from flops.
    always_comb begin
        bus.inq_we      = wr_acc_s;
        bus.inq_wraddr  = wr_acc_s ? free_slot_s : {AW{1'b0}};
        bus.inq_read_en = gnt_s;
        bus.inq_rdaddr  = gnt_s ? head_s : {AW{1'b0}};
        bus.inq_add     = gnt_s && (gnt_idx_s == 2'd0);
        bus.inq_mul     = gnt_s && (gnt_idx_s == 2'd1);
        bus.inq_div     = gnt_s && (gnt_idx_s == 2'd2);
        bus.inq_cnt     = cnt_q;
        bus.inq_full    = full_s;
        bus.inq_ovfl    = ovfl_q;
    end
endmodule

// File: tb/tb_fpu_inq_sched.sv
// Directed table-driven bench for fpu_inq_sched: each record is one cycle of
// inputs plus the outputs expected in that same cycle.
module tb_fpu_inq_sched;
    localparam int AW    = 4;
    localparam int P_ADD = 4;
    localparam int P_MUL = 2;
    localparam int P_DIV = 1;

    typedef struct {
        logic          g;
        logic          wv;
        logic [1:0]    wp;
        logic          a;
        logic          m;
        logic          d;
        logic          we;
        logic [AW-1:0] wa;
        logic [2:0]    pul;   // {add, mul, div}
        logic [AW-1:0] ra;
        logic [AW:0]   cnt;
        logic          ov;
    } vec_t;

    logic clk = 1'b0;
    logic grst;
    int   checks = 0;
    int   errors = 0;
    vec_t tbl[$];

    fpu_inq_sched_if #(.AW(AW)) bus ();

    fpu_inq_sched #(.DEPTH(16), .AW(AW)) dut (
        .rclk (clk),
        .grst (grst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input int g, input int wv, input int wp,
                                input int a, input int m, input int d,
                                input int we, input int wa, input int pul,
                                input int ra, input int cnt, input int ov);
        vec_t v;
        v.g   = 1'(g);
        v.wv  = 1'(wv);
        v.wp  = 2'(wp);
        v.a   = 1'(a);
        v.m   = 1'(m);
        v.d   = 1'(d);
        v.we  = 1'(we);
        v.wa  = AW'(wa);
        v.pul = 3'(pul);
        v.ra  = AW'(ra);
        v.cnt = (AW+1)'(cnt);
        v.ov  = 1'(ov);
        return v;
    endfunction

    // Drive one cycle's inputs at the falling edge and check before the rise.
    task automatic run(input vec_t v, input string tag, input int idx);
        logic [19:0] act;
        logic [19:0] exp;
        @(negedge clk);
        grst           = v.g;
        bus.wr_vld     = v.wv;
        bus.wr_pipe    = v.wp;
        bus.a1stg_step = v.a;
        bus.m1stg_step = v.m;
        bus.d1stg_step = v.d;
        #2;
        act = {bus.inq_we, bus.inq_wraddr, bus.inq_read_en, bus.inq_rdaddr,
               bus.inq_add, bus.inq_mul, bus.inq_div, bus.inq_cnt,
               bus.inq_full, bus.inq_ovfl};
        exp = {v.we, v.wa, (v.pul != 3'b000), v.ra, v.pul, v.cnt,
               (v.cnt == 5'd16), v.ov};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] we/wa/re/ra/pul/cnt/full/ovfl got %b/%0d/%b/%0d/%b/%0d/%b/%b want %b/%0d/%b/%0d/%b/%0d/%b/%b",
                     tag, idx, act[19], act[18:15], act[14], act[13:10], act[9:7],
                     act[6:2], act[1], act[0], exp[19], exp[18:15], exp[14],
                     exp[13:10], exp[9:7], exp[6:2], exp[1], exp[0]);
        end
    endtask

    initial begin
        grst           = 1'b1;
        bus.wr_vld     = 1'b0;
        bus.wr_pipe    = 2'b00;
        bus.a1stg_step = 1'b0;
        bus.m1stg_step = 1'b0;
        bus.d1stg_step = 1'b0;
        repeat (2) @(negedge clk);

        // Post-reset idle state
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0, 0,0));
        // div, add, mul with all steps on; slot 0 is reused once div issues
        tbl.push_back(mk(0,1,3, 1,1,1, 1,0, 0,0,     0,0));
        tbl.push_back(mk(0,1,1, 1,1,1, 1,1, P_DIV,0, 1,0));
        tbl.push_back(mk(0,1,2, 1,1,1, 1,0, P_ADD,1, 1,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_MUL,0, 1,0));
        tbl.push_back(mk(0,1,0, 1,1,1, 0,0, 0,0,     0,0));  // pipe 00 rejected
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, 0,0,     0,0));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,0, 0,0,     0,0));
        // Stalled divide does not block adds
        tbl.push_back(mk(0,1,3, 0,0,0, 1,0, 0,0,     0,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,1, 0,0,     1,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,2, 0,0,     2,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,3, 0,0,     3,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0, P_ADD,1, 4,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0, P_ADD,2, 3,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0, P_ADD,3, 2,0));
        tbl.push_back(mk(0,0,0, 1,0,0, 0,0, 0,0,     1,0));
        tbl.push_back(mk(0,0,0, 1,0,1, 0,0, P_DIV,0, 1,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,     0,0));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,0, 0,0,     0,0));
        // Contention: 2 adds, 2 muls, 2 divs, then round-robin drain
        tbl.push_back(mk(0,1,1, 0,0,0, 1,0, 0,0,     0,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,1, 0,0,     1,0));
        tbl.push_back(mk(0,1,2, 0,0,0, 1,2, 0,0,     2,0));
        tbl.push_back(mk(0,1,2, 0,0,0, 1,3, 0,0,     3,0));
        tbl.push_back(mk(0,1,3, 0,0,0, 1,4, 0,0,     4,0));
        tbl.push_back(mk(0,1,3, 0,0,0, 1,5, 0,0,     5,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_ADD,0, 6,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_MUL,2, 5,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_DIV,4, 4,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_ADD,1, 3,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_MUL,3, 2,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_DIV,5, 1,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, 0,0,     0,0));
        tbl.push_back(mk(1,0,0, 0,0,0, 0,0, 0,0,     0,0));
        // Reset mid-operation with 5 entries queued
        tbl.push_back(mk(0,1,1, 0,0,0, 1,0, 0,0,     0,0));
        tbl.push_back(mk(0,1,2, 0,0,0, 1,1, 0,0,     1,0));
        tbl.push_back(mk(0,1,3, 0,0,0, 1,2, 0,0,     2,0));
        tbl.push_back(mk(0,1,1, 0,0,0, 1,3, 0,0,     3,0));
        tbl.push_back(mk(0,1,2, 0,0,0, 1,4, 0,0,     4,0));
        tbl.push_back(mk(1,1,1, 1,1,1, 0,0, 0,0,     5,0));
        tbl.push_back(mk(0,1,1, 1,1,1, 1,0, 0,0,     0,0));
        tbl.push_back(mk(0,0,0, 1,1,1, 0,0, P_ADD,0, 1,0));
        tbl.push_back(mk(0,0,0, 0,0,0, 0,0, 0,0,     0,0));

        foreach (tbl[i]) run(tbl[i], "tbl", i);

        // Fill all 16 slots, overflow, then full-plus-issue corner
        run(mk(1,0,0, 0,0,0, 0,0, 0,0, 0,0), "full_rst", 0);
        for (int i = 0; i < 16; i++) begin
            run(mk(0,1,1, 0,0,0, 1,i, 0,0, i,0), "fill", i);
        end
        run(mk(0,1,1, 0,0,0, 0,0, 0,0,     16,0), "ovfl_wr", 0);
        run(mk(0,1,1, 1,0,0, 0,0, P_ADD,0, 16,1), "full_issue", 0);
        run(mk(0,1,1, 0,0,0, 1,0, 0,0,     15,1), "refill", 0);
        run(mk(0,0,0, 0,0,0, 0,0, 0,0,     16,1), "refull", 0);
        run(mk(1,0,0, 0,0,0, 0,0, 0,0,     16,1), "full_rst", 1);

        // 40 add write/issue pairs: slots alternate, FIFO pointers wrap
        for (int i = 0; i < 40; i++) begin
            if (i == 0) begin
                run(mk(0,1,1, 1,0,0, 1,0, 0,0, 0,0), "wrap", i);
            end else begin
                run(mk(0,1,1, 1,0,0, 1,i%2, P_ADD,(i-1)%2, 1,0), "wrap", i);
            end
        end
        run(mk(0,0,0, 1,0,0, 0,0, P_ADD,1, 1,0), "wrap_drain", 0);
        run(mk(0,0,0, 0,0,0, 0,0, 0,0,     0,0), "wrap_drain", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
